// File: rtl/kbd_playback_ctrl.sv
// kbd_playback_ctrl
// Keyboard-driven playback control for the audio-player datapath: decodes
// single ASCII key commands (play/stop/direction/restart/speed), owns the
// sample-address counter and divides sample_tick down to the playback speed.
// Optional build macro KBD_ONESHOT_EN: the clip stops at its end instead of
// wrapping and end_pulse fires once; without it end_pulse is tied low.
module kbd_playback_ctrl #(
    parameter int         ADDR_W   = 23,
    parameter int         DEPTH    = 2**23,
    parameter int         DIV_W    = 4,
    parameter int         DIV_DEF  = 1,
    parameter int         DIV_MAX  = 15,
    parameter logic [7:0] KEY_STOP = 8'h44,
    parameter logic [7:0] KEY_PLAY = 8'h45,
    parameter logic [7:0] KEY_BWD  = 8'h42,
    parameter logic [7:0] KEY_FWD  = 8'h46,
    parameter logic [7:0] KEY_RST  = 8'h52,
    parameter logic [7:0] KEY_FAST = 8'h55,
    parameter logic [7:0] KEY_SLOW = 8'h4C
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        ascii_code,
    input  logic              sample_tick,
    output logic              pause,
    output logic              reverse,
    output logic              restart,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_strobe,
    output logic [DIV_W-1:0]  speed_div,
    output logic              end_pulse
);

    localparam logic [1:0]        ST_STOP   = 2'd0;
    localparam logic [1:0]        ST_FWD    = 2'd1;
    localparam logic [1:0]        ST_BWD    = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0]  DIV_TOP   = DIV_W'(DIV_MAX);
    localparam logic [DIV_W-1:0]  DIV_INIT  = DIV_W'(DIV_DEF);

    logic [1:0]        state_r, state_s;
    logic              dir_r, dir_s;
    logic [7:0]        key_prev_r;
    logic [DIV_W-1:0]  cnt_r, cnt_s;
    logic [DIV_W-1:0]  speed_r, speed_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic              restart_r, restart_s;
    logic              strobe_r, strobe_s;
    logic              pause_r;
    logic              key_fire_s;
    logic              key_drops_tick_s;
    logic              tick_ok_s;
    logic              play_block_s;

`ifdef KBD_ONESHOT_EN
    logic              end_r, end_s;
    logic              at_end_r, at_end_s;
    assign play_block_s = at_end_r;
    assign end_pulse    = end_r;
`else
    assign play_block_s = 1'b0;
    assign end_pulse    = 1'b0;
`endif

    // Key edge detect; restart and speed commands swallow a coincident tick.
    always_comb begin
        key_fire_s       = (ascii_code != 8'h00) && (ascii_code != key_prev_r);
        key_drops_tick_s = key_fire_s && ((ascii_code == KEY_RST) ||
                                          (ascii_code == KEY_FAST) ||
                                          (ascii_code == KEY_SLOW));
        tick_ok_s        = sample_tick && (state_r != ST_STOP) && !key_drops_tick_s;
    end

    // Next state: the tick advances against the registered state, then a fired key overrides.
    always_comb begin
        state_s   = state_r;
        dir_s     = dir_r;
        cnt_s     = cnt_r;
        speed_s   = speed_r;
        addr_s    = addr_r;
        restart_s = 1'b0;
        strobe_s  = 1'b0;
`ifdef KBD_ONESHOT_EN
        end_s     = 1'b0;
        at_end_s  = at_end_r;
`endif
        if (tick_ok_s) begin
            if (cnt_r >= speed_r - DIV_ONE) begin
                cnt_s = '0;
                if (state_r == ST_FWD) begin
                    if (addr_r == ADDR_LAST) begin
`ifdef KBD_ONESHOT_EN
                        state_s  = ST_STOP;
                        end_s    = 1'b1;
                        at_end_s = 1'b1;
`else
                        addr_s   = '0;
                        strobe_s = 1'b1;
`endif
                    end else begin
                        addr_s   = addr_r + ADDR_ONE;
                        strobe_s = 1'b1;
                    end
                end else begin
                    if (addr_r == '0) begin
`ifdef KBD_ONESHOT_EN
                        state_s  = ST_STOP;
                        end_s    = 1'b1;
                        at_end_s = 1'b1;
`else
                        addr_s   = ADDR_LAST;
                        strobe_s = 1'b1;
`endif
                    end else begin
                        addr_s   = addr_r - ADDR_ONE;
                        strobe_s = 1'b1;
                    end
                end
            end else begin
                cnt_s = cnt_r + DIV_ONE;
            end
        end else begin
            cnt_s = cnt_r;
        end

        if (key_fire_s) begin
            case (ascii_code)
                KEY_STOP: state_s = ST_STOP;
                KEY_PLAY: begin
                    if ((state_r == ST_STOP) && !play_block_s) begin
                        state_s = dir_r ? ST_BWD : ST_FWD;
                    end else begin
                        state_s = state_r;
                    end
                end
                KEY_FWD: begin
                    dir_s = 1'b0;
                    if (state_s != ST_STOP) begin
                        state_s = ST_FWD;
                    end else begin
                        state_s = ST_STOP;
                    end
`ifdef KBD_ONESHOT_EN
                    at_end_s = 1'b0;
`endif
                end
                KEY_BWD: begin
                    dir_s = 1'b1;
                    if (state_s != ST_STOP) begin
                        state_s = ST_BWD;
                    end else begin
                        state_s = ST_STOP;
                    end
`ifdef KBD_ONESHOT_EN
                    at_end_s = 1'b0;
`endif
                end
                KEY_RST: begin
                    addr_s    = dir_r ? ADDR_LAST : '0;
                    cnt_s     = '0;
                    restart_s = 1'b1;
`ifdef KBD_ONESHOT_EN
                    at_end_s  = 1'b0;
`endif
                end
                KEY_FAST: begin
                    speed_s = (speed_r > DIV_ONE) ? (speed_r - DIV_ONE) : DIV_ONE;
                    cnt_s   = '0;
                end
                KEY_SLOW: begin
                    speed_s = (speed_r < DIV_TOP) ? (speed_r + DIV_ONE) : DIV_TOP;
                    cnt_s   = '0;
                end
                default: begin
                    state_s = state_s;
                end
            endcase
        end else begin
            restart_s = 1'b0;
        end
    end

    // Control and address registers; reset_n aborts any activity immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_STOP;
            dir_r      <= 1'b0;
            key_prev_r <= 8'h00;
            cnt_r      <= '0;
            speed_r    <= DIV_INIT;
            addr_r     <= '0;
            restart_r  <= 1'b0;
            strobe_r   <= 1'b0;
            pause_r    <= 1'b1;
        end else begin
            state_r    <= state_s;
            dir_r      <= dir_s;
            key_prev_r <= ascii_code;
            cnt_r      <= cnt_s;
            speed_r    <= speed_s;
            addr_r     <= addr_s;
            restart_r  <= restart_s;
            strobe_r   <= strobe_s;
            pause_r    <= (state_s == ST_STOP);
        end
    end

`ifdef KBD_ONESHOT_EN
    // End-of-clip pulse and the latch that blocks play until restart or a direction key.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            end_r    <= 1'b0;
            at_end_r <= 1'b0;
        end else begin
            end_r    <= end_s;
            at_end_r <= at_end_s;
        end
    end
`endif

    assign pause       = pause_r;
    assign reverse     = dir_r;
    assign restart     = restart_r;
    assign addr        = addr_r;
    assign addr_strobe = strobe_r;
    assign speed_div   = speed_r;

endmodule

// File: tb/tb_kbd_playback_ctrl.sv
// Testbench for kbd_playback_ctrl (DEPTH=8, DIV_DEF=1). A behavioural model
// tracks playing/direction/address/divider as plain integers and is advanced
// once per clock alongside the stimulus.
module tb_kbd_playback_ctrl;

    localparam int         AW    = 3;
    localparam int         DEPTH = 8;
    localparam logic [7:0] K_D   = 8'h44;
    localparam logic [7:0] K_E   = 8'h45;
    localparam logic [7:0] K_B   = 8'h42;
    localparam logic [7:0] K_F   = 8'h46;
    localparam logic [7:0] K_R   = 8'h52;
    localparam logic [7:0] K_U   = 8'h55;
    localparam logic [7:0] K_L   = 8'h4C;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [7:0]    ascii_code;
    logic          sample_tick;
    logic          pause, reverse, restart, addr_strobe, end_pulse;
    logic [AW-1:0] addr;
    logic [3:0]    speed_div;
    logic [11:0]   obs_vec;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit         m_play, m_dir, m_rs, m_st, m_end, m_at_end;
    int         m_addr, m_cnt, m_div;
    logic [7:0] m_prev;

    kbd_playback_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH), .DIV_W(4), .DIV_DEF(1), .DIV_MAX(15)) dut (
        .clk(clk), .reset_n(reset_n), .ascii_code(ascii_code), .sample_tick(sample_tick),
        .pause(pause), .reverse(reverse), .restart(restart), .addr(addr),
        .addr_strobe(addr_strobe), .speed_div(speed_div), .end_pulse(end_pulse)
    );

    always #5 clk = ~clk;

    assign obs_vec = {pause, reverse, restart, addr, addr_strobe, speed_div, end_pulse};

    function automatic logic [11:0] exp_vec();
        return {~m_play, m_dir, m_rs, AW'(m_addr), m_st, 4'(m_div), m_end};
    endfunction

    task automatic model_reset();
        m_play = 0; m_dir = 0; m_rs = 0; m_st = 0; m_end = 0; m_at_end = 0;
        m_addr = 0; m_cnt = 0; m_div = 1; m_prev = 8'h00;
    endtask

    // Apply one cycle of input, advance the model, and land at posedge+1.
    task automatic step(input logic [7:0] k, input logic t);
        bit fire, tick_ok, n_play, n_dir, n_rs, n_st, n_end, n_at_end;
        int n_addr, n_cnt, n_div;
        ascii_code  = k;
        sample_tick = t;
        fire   = (k != 8'h00) && (k != m_prev);
        n_play = m_play; n_dir = m_dir; n_addr = m_addr; n_cnt = m_cnt; n_div = m_div;
        n_rs = 0; n_st = 0; n_end = 0; n_at_end = m_at_end;
        tick_ok = t && m_play && !(fire && (k == K_R || k == K_U || k == K_L));
        if (tick_ok) begin
            if (m_cnt + 1 >= m_div) begin
                n_cnt = 0;
`ifdef KBD_ONESHOT_EN
                if ((!m_dir && m_addr == DEPTH - 1) || (m_dir && m_addr == 0)) begin
                    n_play = 0; n_end = 1; n_at_end = 1;
                end else begin
                    n_addr = m_dir ? m_addr - 1 : m_addr + 1;
                    n_st = 1;
                end
`else
                n_addr = (m_addr + (m_dir ? DEPTH - 1 : 1)) % DEPTH;
                n_st = 1;
`endif
            end else begin
                n_cnt = m_cnt + 1;
            end
        end
        if (fire) begin
            if (k == K_D) n_play = 0;
            else if (k == K_E) begin
                if (!m_play && !m_at_end) n_play = 1;
            end
            else if (k == K_F) begin n_dir = 0; n_at_end = 0; end
            else if (k == K_B) begin n_dir = 1; n_at_end = 0; end
            else if (k == K_R) begin
                n_addr = m_dir ? DEPTH - 1 : 0; n_cnt = 0; n_rs = 1; n_at_end = 0;
            end
            else if (k == K_U) begin n_div = (m_div > 1) ? m_div - 1 : 1; n_cnt = 0; end
            else if (k == K_L) begin n_div = (m_div < 15) ? m_div + 1 : 15; n_cnt = 0; end
        end
        m_prev = k;
        @(posedge clk);
        #1;
        m_play = n_play; m_dir = n_dir; m_addr = n_addr; m_cnt = n_cnt; m_div = n_div;
        m_rs = n_rs; m_st = n_st; m_end = n_end; m_at_end = n_at_end;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ascii_code = 8'h00; sample_tick = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_vec !== 12'b1_0_0_000_0_0001_0) begin
            n_bad++; $display("FAIL reset_state: got %b want %b", obs_vec, 12'b1_0_0_000_0_0001_0);
        end
        #2 reset_n = 1'b1;
        step(8'h00, 1'b1);
        n_cmp++;
        if (obs_vec !== exp_vec()) begin
            n_bad++; $display("FAIL reset_tick_ignored: got %b want %b", obs_vec, exp_vec());
        end
    endtask

    task automatic test_play();
        int   falls = 0;
        logic last_p;
        last_p = pause;
        for (int i = 0; i < 5; i++) begin
            step(K_E, 1'b0);
            if (last_p && !pause) falls++;
            last_p = pause;
        end
        n_cmp++;
        if (falls !== 1 || pause !== 1'b0 || reverse !== 1'b0) begin
            n_bad++; $display("FAIL play_start: falls=%0d pause=%b rev=%b want 1/0/0", falls, pause, reverse);
        end
        for (int i = 0; i < 4; i++) begin
            step(8'h00, 1'b1);
            n_cmp++;
            if (addr !== AW'(i + 1) || addr_strobe !== 1'b1 || obs_vec !== exp_vec()) begin
                n_bad++; $display("FAIL play_addr[%0d]: got %b want addr=%0d vec %b", i, obs_vec, i + 1, exp_vec());
            end
        end
        step(8'h00, 1'b0);
        n_cmp++;
        if (addr_strobe !== 1'b0 || addr !== 3'd4) begin
            n_bad++; $display("FAIL play_idle: got strobe=%b addr=%0d want 0/4", addr_strobe, addr);
        end
    endtask

    task automatic test_wrap();
        repeat (3) step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        n_cmp++;
        if (addr !== 3'd0 || addr_strobe !== 1'b1) begin
            n_bad++; $display("FAIL wrap_fwd: got addr=%0d strobe=%b want 0/1", addr, addr_strobe);
        end
        step(K_B, 1'b0);
        step(K_B, 1'b1);
        n_cmp++;
        if (addr !== 3'd7 || reverse !== 1'b1 || obs_vec !== exp_vec()) begin
            n_bad++; $display("FAIL wrap_bwd: got %b want addr=7 rev=1 vec %b", obs_vec, exp_vec());
        end
        step(K_B, 1'b0);
        n_cmp++;
        if (addr !== 3'd7 || reverse !== 1'b1 || pause !== 1'b0) begin
            n_bad++; $display("FAIL held_b: got addr=%0d rev=%b pause=%b want 7/1/0", addr, reverse, pause);
        end
        step(8'h00, 1'b0);
    endtask

    task automatic test_stop_resume();
        repeat (4) step(8'h00, 1'b1);
        step(K_D, 1'b0);
        n_cmp++;
        if (addr !== 3'd3 || pause !== 1'b1 || reverse !== 1'b1) begin
            n_bad++; $display("FAIL stop: got addr=%0d pause=%b rev=%b want 3/1/1", addr, pause, reverse);
        end
        step(8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 1'b1);
            n_cmp++;
            if (addr !== 3'd3 || addr_strobe !== 1'b0) begin
                n_bad++; $display("FAIL stopped_tick[%0d]: got addr=%0d strobe=%b want 3/0", i, addr, addr_strobe);
            end
        end
        step(K_E, 1'b0);
        step(8'h00, 1'b1);
        n_cmp++;
        if (addr !== 3'd2 || pause !== 1'b0 || obs_vec !== exp_vec()) begin
            n_bad++; $display("FAIL resume_bwd: got %b want addr=2 vec %b", obs_vec, exp_vec());
        end
    endtask

    task automatic test_speed();
        int strobes = 0;
        step(K_U, 1'b0);
        n_cmp++;
        if (speed_div !== 4'd1) begin
            n_bad++; $display("FAIL fast_sat: got %0d want 1", speed_div);
        end
        for (int i = 0; i < 20; i++) begin
            step(K_L, 1'b0);
            step(8'h00, 1'b0);
        end
        n_cmp++;
        if (speed_div !== 4'd15) begin
            n_bad++; $display("FAIL slow_sat: got %0d want 15", speed_div);
        end
        for (int i = 0; i < 13; i++) begin
            step(K_U, 1'b0);
            step(8'h00, 1'b0);
        end
        n_cmp++;
        if (speed_div !== 4'd2) begin
            n_bad++; $display("FAIL div2: got %0d want 2", speed_div);
        end
        for (int i = 0; i < 6; i++) begin
            step(8'h00, 1'b1);
            if (addr_strobe === 1'b1) strobes++;
            n_cmp++;
            if (obs_vec !== exp_vec()) begin
                n_bad++; $display("FAIL div2_tick[%0d]: got %b want %b", i, obs_vec, exp_vec());
            end
        end
        n_cmp++;
        if (strobes !== 3) begin
            n_bad++; $display("FAIL div2_count: got %0d strobes want 3", strobes);
        end
    endtask

    task automatic test_restart();
        step(K_U, 1'b0);
        for (int i = 0; i < 10 && m_addr != 2; i++) step(8'h00, 1'b1);
        n_cmp++;
        if (addr !== 3'd2 || reverse !== 1'b1 || pause !== 1'b0) begin
            n_bad++; $display("FAIL restart_setup: got addr=%0d rev=%b pause=%b want 2/1/0", addr, reverse, pause);
        end
        step(K_R, 1'b1);
        n_cmp++;
        if (addr !== 3'd7 || restart !== 1'b1 || addr_strobe !== 1'b0) begin
            n_bad++; $display("FAIL restart_tick: got addr=%0d rs=%b strobe=%b want 7/1/0", addr, restart, addr_strobe);
        end
        step(8'h00, 1'b0);
        n_cmp++;
        if (addr !== 3'd7 || restart !== 1'b0 || obs_vec !== exp_vec()) begin
            n_bad++; $display("FAIL restart_pulse: got %b want addr=7 rs=0 vec %b", obs_vec, exp_vec());
        end
    endtask

    task automatic test_async_reset();
        step(K_L, 1'b1);
        step(8'h00, 1'b1);
        reset_n = 1'b0;
        #2;
        n_cmp++;
        if (obs_vec !== 12'b1_0_0_000_0_0001_0) begin
            n_bad++; $display("FAIL async_reset: got %b want %b", obs_vec, 12'b1_0_0_000_0_0001_0);
        end
        model_reset();
        ascii_code = 8'h00; sample_tick = 1'b0;
        #2 reset_n = 1'b1;
        step(8'h00, 1'b1);
        n_cmp++;
        if (obs_vec !== exp_vec()) begin
            n_bad++; $display("FAIL post_reset: got %b want %b", obs_vec, exp_vec());
        end
    endtask

    task automatic test_oneshot();
        step(K_E, 1'b0);
        for (int i = 0; i < 7; i++) step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        n_cmp++;
        if (addr !== 3'd7 || pause !== 1'b1 || end_pulse !== 1'b1) begin
            n_bad++; $display("FAIL oneshot_end: got addr=%0d pause=%b end=%b want 7/1/1", addr, pause, end_pulse);
        end
        step(8'h00, 1'b0);
        n_cmp++;
        if (end_pulse !== 1'b0) begin
            n_bad++; $display("FAIL oneshot_pulse: got end=%b want 0", end_pulse);
        end
        step(K_E, 1'b0);
        n_cmp++;
        if (pause !== 1'b1) begin
            n_bad++; $display("FAIL oneshot_blocked: got pause=%b want 1", pause);
        end
        step(K_R, 1'b0);
        step(K_E, 1'b0);
        step(8'h00, 1'b1);
        n_cmp++;
        if (addr !== 3'd1 || pause !== 1'b0 || obs_vec !== exp_vec()) begin
            n_bad++; $display("FAIL oneshot_replay: got %b want addr=1 vec %b", obs_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [7:0] keys [10];
        logic [7:0] k;
        keys = '{8'h00, 8'h00, K_D, K_E, K_F, K_B, K_R, K_U, K_L, 8'h41};
        k = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 19) == 0) k = 8'($urandom);
                else k = keys[$urandom_range(0, 9)];
            end
            step(k, 1'($urandom_range(0, 1)));
            n_cmp++;
            if (obs_vec !== exp_vec()) begin
                n_bad++; $display("FAIL random[%0d] key=%h: got %b want %b", i, k, obs_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_play();
`ifdef KBD_ONESHOT_EN
        test_async_reset();
        test_oneshot();
`else
        test_wrap();
        test_stop_resume();
        test_speed();
        test_restart();
        test_async_reset();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
